// File: rtl/prbs8_pkg.sv
// Shared PRBS8 definitions for the generator and checker sides.
package prbs8_pkg;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} prbs8_state_t;

  // Feedback taps on bits 4,3,2,0; feedback enters at bit 7.
  localparam logic [7:0] PRBS8_TAPS = 8'h1D;

  localparam logic [15:0] PRBS8_BCD_MAX = 16'h9999;

  function automatic logic [7:0] prbs8_next(input logic [7:0] s);
    return {^(s & PRBS8_TAPS), s[7:1]};
  endfunction

endpackage

// File: rtl/prbs8_bcd_cnt.sv
// Four-digit saturating BCD event counter (0..9999), 1-cycle update.
// clr wins over the old value but not over a same-cycle inc, which lands as 0001.
module prbs8_bcd_cnt
  import prbs8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] bcd
);

  logic [15:0] bcd_inc;
  logic        carry;

  always_comb begin
    bcd_inc = bcd;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd <= 16'h0000;
    end else if (clr) begin
      bcd <= inc ? 16'h0001 : 16'h0000;
    end else if (inc && bcd != PRBS8_BCD_MAX) begin
      bcd <= bcd_inc;
    end
  end

endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising PRBS8 checker with lock FSM and saturating error counters; outputs registered, 1-cycle latency.
// No backpressure: acts only on in_valid cycles. err_bcd is built only when PRBS8_CHK_BCD_EN is defined.
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        clear,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [15:0] err_bcd
);

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_LIM = 4'(LOSS_CNT);

  prbs8_state_t state_q, state_d;
  logic [7:0]   exp_q, exp_d;
  logic [3:0]   run_q, run_d, run_inc;
  logic [3:0]   bad_q, bad_d, bad_inc;
  logic [15:0]  cnt_d;
  logic         hit;
  logic         count_err;

  // exp is never zero once seeded, but a zero sample must never count as a hit.
  assign hit     = (in_data == exp_q) && (in_data != 8'h00);
  assign run_inc = run_q + 4'd1;
  assign bad_inc = bad_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    run_d     = run_q;
    bad_d     = bad_q;
    count_err = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (in_data != 8'h00) begin
            exp_d   = prbs8_next(in_data);
            run_d   = 4'd0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            run_d = run_inc;
            exp_d = prbs8_next(exp_q);
            if (run_inc == LOCK_LIM) begin
              state_d = LOCKED;
              bad_d   = 4'd0;
            end
          end else if (in_data != 8'h00) begin
            exp_d = prbs8_next(in_data);
            run_d = 4'd0;
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // Flywheel: never reseed from received data while locked.
          exp_d = prbs8_next(exp_q);
          if (hit) begin
            bad_d = 4'd0;
          end else begin
            count_err = 1'b1;
            bad_d     = bad_inc;
            if (bad_inc == LOSS_LIM) state_d = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    cnt_d = err_count;
    if (clear) begin
      cnt_d = {15'd0, count_err};
    end else if (count_err && err_count != 16'hFFFF) begin
      cnt_d = err_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEARCH;
      exp_q     <= 8'h00;
      run_q     <= 4'd0;
      bad_q     <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= 16'h0000;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      run_q     <= run_d;
      bad_q     <= bad_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= count_err;
      err_count <= cnt_d;
    end
  end

`ifdef PRBS8_CHK_BCD_EN
  prbs8_bcd_cnt u_bcd (
    .clk (clk),
    .rst (rst),
    .inc (count_err),
    .clr (clear),
    .bcd (err_bcd)
  );
`else
  assign err_bcd = 16'h0000;
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// Scoreboard bench for prbs8_checker: directed LFSR vectors with hand-derived lock/error expectations.
module tb_prbs8_checker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] err_bcd;

`ifdef PRBS8_CHK_BCD_EN
  localparam bit BCD_EN = 1'b1;
`else
  localparam bit BCD_EN = 1'b0;
`endif

  typedef struct {
    logic        lk;
    logic        pl;
    logic [15:0] cnt;
    logic [15:0] bcd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt = 0;
  int   m_dec = 0;

  prbs8_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .err_bcd   (err_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_bcd(input int n);
    logic [15:0] b;
    b = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    return BCD_EN ? b : 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // One valid sample; lk/er are the hand-derived lock state and error flag after it.
  task automatic send(input logic [7:0] d, input logic lk, input logic er, input logic clr = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    clear    = clr;
    if (clr) begin
      m_cnt = 0;
      m_dec = 0;
    end
    if (er) begin
      if (m_cnt < 16'hFFFF) m_cnt++;
      if (m_dec < 9999) m_dec++;
    end
    e.lk  = lk;
    e.pl  = er;
    e.cnt = 16'(m_cnt);
    e.bcd = exp_bcd(m_dec);
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear    = 1'b0;
  endtask

  initial begin : monitor
    logic v;
    logic rs;
    exp_t e;
    forever begin
      @(posedge clk);
      v  = in_valid | clear;
      rs = rst;
      @(negedge clk);
      if (!rs && !rst) begin
        if (v) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 16'd1, 16'd0);
          end else begin
            e = sb.pop_front();
            chk("locked", {15'd0, locked}, {15'd0, e.lk});
            chk("err_pulse", {15'd0, err_pulse}, {15'd0, e.pl});
            chk("err_count", err_count, e.cnt);
            chk("err_bcd", err_bcd, e.bcd);
          end
        end else begin
          chk("idle_pulse", {15'd0, err_pulse}, 16'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear    = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_locked", {15'd0, locked}, 16'd0);
    chk("rst_pulse", {15'd0, err_pulse}, 16'd0);
    chk("rst_count", err_count, 16'd0);
    chk("rst_bcd", err_bcd, 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero in SEARCH holds; zero in VERIFY drops back so 80 must reseed.
    send(8'h00, 0, 0); send(8'h01, 0, 0); send(8'h00, 0, 0);
    send(8'h80, 0, 0); send(8'h40, 0, 0); send(8'h20, 0, 0);
    send(8'h10, 0, 0); send(8'h88, 1, 0);
    // Loss of lock: three wrong samples, third drops lock but still counts.
    send(8'h00, 1, 1); send(8'h5A, 1, 1); send(8'h5A, 0, 1);
    // Reseed in VERIFY on 33, then clean run from 33 locks, nothing counted.
    send(8'h01, 0, 0); send(8'h33, 0, 0); send(8'h19, 0, 0);
    send(8'h8C, 0, 0); send(8'h46, 0, 0); send(8'hA3, 1, 0);
    // Clear on a matching sample, then lose lock again.
    send(8'hD1, 1, 0, 1'b1);
    send(8'h00, 1, 1); send(8'h00, 1, 1); send(8'h00, 0, 1);
    // Clean acquisition.
    send(8'h01, 0, 0); send(8'h80, 0, 0); send(8'h40, 0, 0);
    send(8'h20, 0, 0); send(8'h10, 1, 0);
    idle();
    // Single error (55 for 88) then resume on the flywheel stream.
    send(8'h55, 1, 1); send(8'hC4, 1, 0);
    idle();
    send(8'hE2, 1, 0); send(8'h71, 1, 0);
    // Fifth error, then clear colliding with a counted error.
    send(8'hAA, 1, 1); send(8'h1C, 1, 0);
    send(8'h00, 1, 1, 1'b1); send(8'h47, 1, 0);
    idle();

    // Preload near saturation.
    @(posedge clk);
    #1;
    force dut.err_count = 16'hFFFE;
`ifdef PRBS8_CHK_BCD_EN
    force dut.u_bcd.bcd = 16'h9998;
`endif
    #1;
    release dut.err_count;
`ifdef PRBS8_CHK_BCD_EN
    release dut.u_bcd.bcd;
`endif
    m_cnt = 16'hFFFE;
    m_dec = 9998;
    send(8'h00, 1, 1); send(8'h91, 1, 0);
    send(8'h00, 1, 1); send(8'hA4, 1, 0);
    send(8'h00, 1, 1);
    idle();
    idle();

    // Asynchronous reset mid-cycle.
    #3 rst = 1'b1;
    #1;
    chk("arst_locked", {15'd0, locked}, 16'd0);
    chk("arst_pulse", {15'd0, err_pulse}, 16'd0);
    chk("arst_count", err_count, 16'd0);
    chk("arst_bcd", err_bcd, 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_cnt = 0;
    m_dec = 0;
    // State must be back in SEARCH: 48 seeds rather than mismatching.
    send(8'h48, 0, 0); send(8'hA4, 0, 0);
    idle();
    idle();
    idle();
    chk("sb_drain", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
